// File: rtl/vscale_dmem_scheduler_if.sv
// ----------------------------------------------------------------------------
// vscale_dmem_scheduler_if
//   Bundles the signals the DMEM scheduler observes on both cores' AHB-lite
//   address phase together with the grant signals it returns to the arbiter.
//
//   master modport : arbiter / core side (drives transfer info, reads grant)
//   slave  modport : scheduler side (reads transfer info, drives grant)
//
//   core_htrans_0/1     HASTI_TRANS_WIDTH  transfer type per core
//   core_hmastlock_0/1  1                  locked-sequence flag per core
//   dmem_hready         1                  DMEM accepts the address phase
//   next_core           CORE_IDX_WIDTH     owner for the next cycle
//   cur_core            CORE_IDX_WIDTH     registered current owner
//   sched_state         2                  scheduler FSM state (0 IDLE, 1 RUN, 2 LOCK)
// ----------------------------------------------------------------------------
interface vscale_dmem_scheduler_if;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int CORE_IDX_WIDTH    = 1;

  logic [HASTI_TRANS_WIDTH-1:0] core_htrans_0;
  logic [HASTI_TRANS_WIDTH-1:0] core_htrans_1;
  logic                         core_hmastlock_0;
  logic                         core_hmastlock_1;
  logic                         dmem_hready;
  logic [CORE_IDX_WIDTH-1:0]    next_core;
  logic [CORE_IDX_WIDTH-1:0]    cur_core;
  logic [1:0]                   sched_state;

  modport master (
    output core_htrans_0, core_htrans_1,
    output core_hmastlock_0, core_hmastlock_1,
    output dmem_hready,
    input  next_core, cur_core, sched_state
  );

  modport slave (
    input  core_htrans_0, core_htrans_1,
    input  core_hmastlock_0, core_hmastlock_1,
    input  dmem_hready,
    output next_core, cur_core, sched_state
  );
endinterface

// File: rtl/vscale_dmem_scheduler.sv
// ----------------------------------------------------------------------------
// vscale_dmem_scheduler
//   Round-robin owner selection for the shared DMEM port of a two-core vscale
//   system. The current owner keeps the port for up to QUANTUM accepted
//   address phases while the other core waits; ownership never changes while
//   DMEM is stalled or while the owner is inside a locked (hmastlock) sequence.
//   cur_core mirrors the arbiter's own registered owner.
//
//   Parameters
//     QUANTUM     accepted owner beats before yielding to a waiting core (>=1)
//     QCNT_WIDTH  width of the quantum counter, must hold QUANTUM-1
//
//   Ports
//     clk     clock, all state on posedge
//     reset   asynchronous, active-high
//     bus     scheduler side (slave) of vscale_dmem_scheduler_if
//
//   Optional build macro VSCALE_SCHED_STATS_EN adds saturating statistics:
//     sched_switch_cnt  [15:0]  number of grant changes
//     sched_wait_cnt_0  [15:0]  cycles core 0 requested without owning the port
//     sched_wait_cnt_1  [15:0]  cycles core 1 requested without owning the port
// ----------------------------------------------------------------------------
module vscale_dmem_scheduler #(
  parameter int QUANTUM    = 4,
  parameter int QCNT_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  vscale_dmem_scheduler_if.slave  bus
`ifdef VSCALE_SCHED_STATS_EN
  ,
  output logic [15:0]             sched_switch_cnt,
  output logic [15:0]             sched_wait_cnt_0,
  output logic [15:0]             sched_wait_cnt_1
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOCK = 2'd2
  } state_t;

  localparam logic [QCNT_WIDTH-1:0] QLAST = QCNT_WIDTH'(QUANTUM - 1);

  state_t                state_q, state_d;
  logic                  cur_q;
  logic                  next_own;
  logic [QCNT_WIDTH-1:0] qcnt_q, qcnt_d;

  logic req_0, req_1;
  logic req_own, req_oth, lock_own;
  logic accept, lock_hold, do_switch;

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY do not.
  assign req_0 = bus.core_htrans_0[1];
  assign req_1 = bus.core_htrans_1[1];

  assign req_own  = cur_q ? req_1 : req_0;
  assign req_oth  = cur_q ? req_0 : req_1;
  assign lock_own = cur_q ? bus.core_hmastlock_1 : bus.core_hmastlock_0;

  assign accept = bus.dmem_hready & req_own;

  // The owner stays in a locked sequence while it keeps issuing locked beats.
  // State encoding 3 is unreachable and, not being LOCK, behaves as IDLE.
  assign lock_hold = (state_q == ST_LOCK) & req_own & lock_own;

  assign do_switch = bus.dmem_hready & req_oth & ~lock_hold &
                     (~req_own | (accept & (qcnt_q == QLAST) & ~lock_own));

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which is what keeps this block from inferring latches.
  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    next_own = cur_q;

    if (bus.dmem_hready) begin
      next_own = do_switch ? ~cur_q : cur_q;

      // All states leave the same way: the state only records whether the
      // owner is mid-lock, which is what lock_hold needs next cycle.
      if (req_own && lock_own) begin
        state_d = ST_LOCK;
      end else if (req_own) begin
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end

      if (do_switch) begin
        qcnt_d = '0;
      end else if (req_own && lock_own) begin
        // Quantum is ignored while locked; parking the counter at its limit
        // makes the owner yield on its first unlocked beat if the other waits.
        qcnt_d = QLAST;
      end else if (accept && qcnt_q != QLAST) begin
        qcnt_d = qcnt_q + QCNT_WIDTH'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      qcnt_q  <= '0;
      cur_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      cur_q   <= next_own;
    end
  end

  // The arbiter loads next_core on the same edge as cur_q, so force core 0
  // while reset is held to keep both registers in agreement.
  assign bus.next_core   = reset ? 1'b0 : next_own;
  assign bus.cur_core    = cur_q;
  assign bus.sched_state = state_q;

`ifdef VSCALE_SCHED_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sched_switch_cnt <= '0;
      sched_wait_cnt_0 <= '0;
      sched_wait_cnt_1 <= '0;
    end else begin
      if (do_switch && sched_switch_cnt != 16'hFFFF) begin
        sched_switch_cnt <= sched_switch_cnt + 16'd1;
      end
      if (req_0 && cur_q && sched_wait_cnt_0 != 16'hFFFF) begin
        sched_wait_cnt_0 <= sched_wait_cnt_0 + 16'd1;
      end
      if (req_1 && !cur_q && sched_wait_cnt_1 != 16'hFFFF) begin
        sched_wait_cnt_1 <= sched_wait_cnt_1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vscale_dmem_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vscale_dmem_scheduler
//   Directed scenarios plus randomized traffic against a reference model that
//   tracks owner, beats used in the current grant and lock status directly
//   from the scheduling rules. A second instance with QUANTUM=1 covers strict
//   alternation. Build with VSCALE_SCHED_STATS_EN to also cover the counters.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vscale_dmem_scheduler;
  localparam int QUANTUM = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  vscale_dmem_scheduler_if bus ();
  vscale_dmem_scheduler_if bus_q1 ();

  assign bus_q1.core_htrans_0    = bus.core_htrans_0;
  assign bus_q1.core_htrans_1    = bus.core_htrans_1;
  assign bus_q1.core_hmastlock_0 = bus.core_hmastlock_0;
  assign bus_q1.core_hmastlock_1 = bus.core_hmastlock_1;
  assign bus_q1.dmem_hready      = bus.dmem_hready;

`ifdef VSCALE_SCHED_STATS_EN
  logic [15:0] sw_cnt, wt_cnt_0, wt_cnt_1;
  logic [15:0] sw_cnt_q1, wt_cnt_0_q1, wt_cnt_1_q1;
`endif

  vscale_dmem_scheduler #(.QUANTUM(QUANTUM), .QCNT_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef VSCALE_SCHED_STATS_EN
    ,
    .sched_switch_cnt (sw_cnt),
    .sched_wait_cnt_0 (wt_cnt_0),
    .sched_wait_cnt_1 (wt_cnt_1)
`endif
  );

  vscale_dmem_scheduler #(.QUANTUM(1), .QCNT_WIDTH(1)) dut_q1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_q1)
`ifdef VSCALE_SCHED_STATS_EN
    ,
    .sched_switch_cnt (sw_cnt_q1),
    .sched_wait_cnt_0 (wt_cnt_0_q1),
    .sched_wait_cnt_1 (wt_cnt_1_q1)
`endif
  );

  // ---------------------------------------------------------------- model
  logic       m_owner;
  int         m_beats;   // owner beats used in this grant (QUANTUM = spent)
  logic [1:0] m_state;
  int         m_sw, m_w0, m_w1;

  function automatic logic req_of(input logic c);
    return c ? bus.core_htrans_1[1] : bus.core_htrans_0[1];
  endfunction

  function automatic logic lock_of(input logic c);
    return c ? bus.core_hmastlock_1 : bus.core_hmastlock_0;
  endfunction

  // Owner the scheduler should pick for the next cycle.
  function automatic logic m_predict();
    if (reset) return 1'b0;
    if (!bus.dmem_hready || !req_of(~m_owner)) return m_owner;
    if (!req_of(m_owner)) return ~m_owner;
    if (lock_of(m_owner)) return m_owner;
    return (m_beats >= QUANTUM - 1) ? ~m_owner : m_owner;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= 1'b0;
      m_beats <= 0;
      m_state <= 2'd0;
      m_sw    <= 0;
      m_w0    <= 0;
      m_w1    <= 0;
    end else begin
      if (req_of(1'b0) && m_owner && m_w0 < 65535) m_w0 <= m_w0 + 1;
      if (req_of(1'b1) && !m_owner && m_w1 < 65535) m_w1 <= m_w1 + 1;
      if (bus.dmem_hready) begin
        m_owner <= m_predict();
        m_state <= (req_of(m_owner) && lock_of(m_owner)) ? 2'd2 :
                   req_of(m_owner) ? 2'd1 : 2'd0;
        if (m_predict() != m_owner) begin
          m_beats <= 0;
          if (m_sw < 65535) m_sw <= m_sw + 1;
        end else if (req_of(m_owner) && lock_of(m_owner)) begin
          m_beats <= QUANTUM;
        end else if (req_of(m_owner) && m_beats < QUANTUM) begin
          m_beats <= m_beats + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Applies one cycle of inputs at the falling edge; returns mid-low-phase,
  // where outputs are sampled before the next rising edge.
  task automatic drive(input logic [1:0] t0, input logic [1:0] t1,
                       input logic l0, input logic l1, input logic rdy);
    @(negedge clk);
    bus.core_htrans_0    = t0;
    bus.core_htrans_1    = t1;
    bus.core_hmastlock_0 = l0;
    bus.core_hmastlock_1 = l1;
    bus.dmem_hready      = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset                = 1'b1;
    bus.core_htrans_0    = 2'd0;
    bus.core_htrans_1    = 2'd0;
    bus.core_hmastlock_0 = 1'b0;
    bus.core_hmastlock_1 = 1'b0;
    bus.dmem_hready      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.next_core !== 1'b0) begin n_errors++; $display("FAIL rst_next_core: got %0d want 0", bus.next_core); end
    n_checks++; if (bus.cur_core !== 1'b0) begin n_errors++; $display("FAIL rst_cur_core: got %0d want 0", bus.cur_core); end
    n_checks++; if (bus.sched_state !== 2'd0) begin n_errors++; $display("FAIL rst_state: got %0d want 0", bus.sched_state); end
    @(negedge clk);
    reset = 1'b0;
    // Only core 1 requests: it takes the port, then runs.
    drive(2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.next_core !== 1'b1) begin n_errors++; $display("FAIL rst_pre_switch: got %0d want 1", bus.next_core); end
    drive(2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    drive(2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.cur_core !== 1'b1 || bus.sched_state !== 2'd1) begin n_errors++; $display("FAIL rst_pre_run: got cur %0d st %0d want cur 1 st 1", bus.cur_core, bus.sched_state); end
    // Reset asserted mid-cycle must clear state without waiting for an edge.
    reset = 1'b1;
    #1;
    n_checks++; if (bus.next_core !== 1'b0) begin n_errors++; $display("FAIL rst_async_next: got %0d want 0", bus.next_core); end
    n_checks++; if (bus.cur_core !== 1'b0) begin n_errors++; $display("FAIL rst_async_cur: got %0d want 0", bus.cur_core); end
    n_checks++; if (bus.sched_state !== 2'd0) begin n_errors++; $display("FAIL rst_async_state: got %0d want 0", bus.sched_state); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_core();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive((i == 0) ? 2'd2 : 2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (bus.next_core !== 1'b0 || bus.cur_core !== 1'b0) begin n_errors++; $display("FAIL single_owner[%0d]: got next %0d cur %0d want 0 0", i, bus.next_core, bus.cur_core); end
    end
    drive(2'd3, 2'd0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.sched_state !== 2'd1) begin n_errors++; $display("FAIL single_state: got %0d want 1", bus.sched_state); end
  endtask

  task automatic test_quantum();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      drive((k == 0) ? 2'd2 : 2'd3, (k == 0) ? 2'd2 : 2'd3, 1'b0, 1'b0, 1'b1);
      n_checks++; if (bus.cur_core !== 1'((k / 4) % 2)) begin n_errors++; $display("FAIL quantum_cur[%0d]: got %0d want %0d", k, bus.cur_core, (k / 4) % 2); end
      n_checks++; if (bus.next_core !== m_predict()) begin n_errors++; $display("FAIL quantum_next[%0d]: got %0d want %0d", k, bus.next_core, m_predict()); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'd2, 2'd2, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(2'd3, 2'd2, 1'b0, 1'b0, 1'b0);
      n_checks++; if (bus.next_core !== 1'b0 || bus.cur_core !== 1'b0) begin n_errors++; $display("FAIL stall_hold[%0d]: got next %0d cur %0d want 0 0", i, bus.next_core, bus.cur_core); end
    end
    drive(2'd3, 2'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.next_core !== 1'b1) begin n_errors++; $display("FAIL stall_release: got %0d want 1", bus.next_core); end
    drive(2'd3, 2'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.cur_core !== 1'b1) begin n_errors++; $display("FAIL stall_cur: got %0d want 1", bus.cur_core); end
  endtask

  task automatic test_lock();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive((i == 0) ? 2'd2 : 2'd3, 2'd2, 1'b1, 1'b0, 1'b1);
      n_checks++; if (bus.next_core !== 1'b0 || bus.cur_core !== 1'b0) begin n_errors++; $display("FAIL lock_hold[%0d]: got next %0d cur %0d want 0 0", i, bus.next_core, bus.cur_core); end
      if (i > 0) begin
        n_checks++; if (bus.sched_state !== 2'd2) begin n_errors++; $display("FAIL lock_state[%0d]: got %0d want 2", i, bus.sched_state); end
      end
    end
    drive(2'd3, 2'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.next_core !== 1'b1) begin n_errors++; $display("FAIL lock_yield: got %0d want 1", bus.next_core); end
    drive(2'd3, 2'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.cur_core !== 1'b1) begin n_errors++; $display("FAIL lock_after: got %0d want 1", bus.cur_core); end
  endtask

  task automatic test_park();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, 2'd1, 1'b0, 1'b0, 1'b1);
      n_checks++; if (bus.next_core !== 1'b0) begin n_errors++; $display("FAIL park_0[%0d]: got %0d want 0", i, bus.next_core); end
    end
    drive(2'd0, 2'd2, 1'b0, 1'b0, 1'b1);
    n_checks++; if (bus.next_core !== 1'b1) begin n_errors++; $display("FAIL park_oth_switch: got %0d want 1", bus.next_core); end
    for (int i = 0; i < 3; i++) begin
      drive(2'd1, 2'd0, 1'b0, 1'b0, 1'b1);
      n_checks++; if (bus.next_core !== 1'b1 || bus.cur_core !== 1'b1) begin n_errors++; $display("FAIL park_1[%0d]: got next %0d cur %0d want 1 1", i, bus.next_core, bus.cur_core); end
    end
  endtask

  task automatic test_alternation();
    logic exp_owner;
    logic rdy;
    do_reset();
    exp_owner = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      drive(2'd3, 2'd3, 1'b0, 1'b0, rdy);
      n_checks++; if (bus_q1.cur_core !== exp_owner) begin n_errors++; $display("FAIL alt_cur[%0d]: got %0d want %0d", i, bus_q1.cur_core, exp_owner); end
      n_checks++; if (bus_q1.next_core !== (rdy ? ~exp_owner : exp_owner)) begin n_errors++; $display("FAIL alt_next[%0d]: got %0d want %0d", i, bus_q1.next_core, rdy ? ~exp_owner : exp_owner); end
      if (rdy) exp_owner = ~exp_owner;
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0));
      n_checks++; if (bus.next_core !== m_predict()) begin n_errors++; $display("FAIL rand_next[%0d]: got %0d want %0d", i, bus.next_core, m_predict()); end
      n_checks++; if (bus.cur_core !== m_owner) begin n_errors++; $display("FAIL rand_cur[%0d]: got %0d want %0d", i, bus.cur_core, m_owner); end
      n_checks++; if (bus.sched_state !== m_state) begin n_errors++; $display("FAIL rand_state[%0d]: got %0d want %0d", i, bus.sched_state, m_state); end
    end
  endtask

`ifdef VSCALE_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 16; k++) drive(2'd3, 2'd3, 1'b0, 1'b0, 1'b1);
    // 15 edges seen: grant changed after beats 3, 7, 11; core 1 waited
    // beats 0-3 and 8-11, core 0 waited beats 4-7 and 12-14.
    n_checks++; if (sw_cnt !== 16'd3) begin n_errors++; $display("FAIL stats_switch: got %0d want 3", sw_cnt); end
    n_checks++; if (wt_cnt_0 !== 16'd7 || wt_cnt_0 !== 16'(m_w0)) begin n_errors++; $display("FAIL stats_wait0: got %0d want %0d", wt_cnt_0, m_w0); end
    n_checks++; if (wt_cnt_1 !== 16'd8 || wt_cnt_1 !== 16'(m_w1)) begin n_errors++; $display("FAIL stats_wait1: got %0d want %0d", wt_cnt_1, m_w1); end
    // Stalls and random traffic keep counters in step with the model.
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) != 0));
    end
    n_checks++; if (sw_cnt !== 16'(m_sw)) begin n_errors++; $display("FAIL stats_rand_switch: got %0d want %0d", sw_cnt, m_sw); end
    n_checks++; if (wt_cnt_0 !== 16'(m_w0) || wt_cnt_1 !== 16'(m_w1)) begin n_errors++; $display("FAIL stats_rand_wait: got %0d/%0d want %0d/%0d", wt_cnt_0, wt_cnt_1, m_w0, m_w1); end
  endtask
`endif

  initial begin
    reset                = 1'b1;
    bus.core_htrans_0    = 2'd0;
    bus.core_htrans_1    = 2'd0;
    bus.core_hmastlock_0 = 1'b0;
    bus.core_hmastlock_1 = 1'b0;
    bus.dmem_hready      = 1'b1;
    test_reset();
    test_single_core();
    test_quantum();
    test_stall();
    test_lock();
    test_park();
    test_alternation();
    test_random();
`ifdef VSCALE_SCHED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
